// File: rtl/addsub_nibble_seq.sv
// addsub_nibble_seq: wide add/subtract built from one 4-bit slice used
// sequentially, one nibble per cycle, least-significant nibble first.
//   clk, rst        : clock, async active-high reset
//   in_valid/ready  : request handshake (op_sub, a, b captured on accept)
//   out_valid/ready : response handshake (result, carry, overflow, zero)
//   busy            : high whenever not idle
// A request is accepted only in IDLE; the result appears NIBBLES edges later
// and is held until the consumer takes it.

module addsub_nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;

  // Subtract is A + ~B + 1; the +1 arrives as the initial chain carry.
  assign sum  = {1'b0, a} + {1'b0, b ^ {4{sub}}} + {4'b0, cin};
  assign s    = sum[3:0];
  assign cout = sum[4];
endmodule

module addsub_nibble_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         busy
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  state_t        state;
  req_t          req;
  logic [CW-1:0] cnt;
  logic          c;
  logic [W-1:0]  res;
  logic          carry_r, ovf_r, zero_r;

  logic [3:0]    nib_a, nib_b, nib_s;
  logic          nib_c;
  logic [CW+1:0] sh;
  logic [W-1:0]  res_nxt;
  logic          last;

  assign sh    = {cnt, 2'b00};
  assign nib_a = 4'(req.a >> sh);
  assign nib_b = 4'(req.b >> sh);
  assign last  = (cnt == CW'(NIBBLES - 1));

  addsub_nibble_slice u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .sub  (req.sub),
    .cin  (c),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Result with the current nibble merged in; the zero flag is taken from
  // this so it sees the final nibble on the same edge.
  always_comb begin
    res_nxt = (res & ~(W'(4'hf) << sh)) | (W'(nib_s) << sh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req     <= '0;
      cnt     <= '0;
      c       <= 1'b0;
      res     <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req   <= '{sub: op_sub, a: a, b: b};
          c     <= op_sub;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          res <= res_nxt;
          c   <= nib_c;
          cnt <= cnt + 1'b1;
          if (last) begin
            carry_r <= nib_c;
            // Signs of A and effective B agree but the result sign differs.
            ovf_r   <= (req.a[W-1] == (req.b[W-1] ^ req.sub)) &&
                       (nib_s[3] != req.a[W-1]);
            zero_r  <= (res_nxt == '0);
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst so it reads 0 for the whole reset pulse.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res;
  assign carry     = carry_r;
  assign overflow  = ovf_r;
  assign zero      = zero_r;
endmodule

// File: tb/tb_addsub_nibble_seq.sv
module tb_addsub_nibble_seq;
  typedef struct {
    logic [15:0] res;
    bit          carry;
    bit          ovf;
    bit          zero;
    int          due;
  } exp_t;

  logic        clk = 0, rst = 1;
  logic        iv4 = 0, op4 = 0, ordy4 = 1, rdy4, ov4, c4, o4, z4, bz4;
  logic [15:0] a4 = 0, b4 = 0, r4;
  logic        iv1 = 0, op1 = 0, ordy1 = 1, rdy1, ov1, c1, o1, z1, bz1;
  logic [3:0]  a1 = 0, b1 = 0, r1;

  int   checks = 0, failures = 0, cyc = 0;
  bit   rnd_bp = 0;
  exp_t q4[$], q1[$];

  addsub_nibble_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .op_sub(op4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(ordy4), .result(r4),
    .carry(c4), .overflow(o4), .zero(z4), .busy(bz4));

  addsub_nibble_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .op_sub(op1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(ordy1), .result(r1),
    .carry(c1), .overflow(o1), .zero(z1), .busy(bz1));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: whole-word arithmetic, signed overflow from true signed sum.
  function automatic exp_t model(input int w, input bit sub, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint m, half, ua, ub, full, sa, sb, sr;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    full = sub ? ua + ((~ub) & m) + 1 : ua + ub;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    sr   = sub ? sa - sb : sa + sb;
    e.res   = 16'(full & m);
    e.carry = ((full >> w) & 1) != 0;
    e.ovf   = (sr >= half) || (sr < -half);
    e.zero  = (full & m) == 0;
    e.due   = 0;
    return e;
  endfunction

  task automatic drive(input int sel, input bit v, input bit sub, input logic [15:0] a, input logic [15:0] b);
    if (sel == 0) begin iv4 = v; op4 = sub; a4 = a; b4 = b; end
    else begin iv1 = v; op1 = sub; a1 = a[3:0]; b1 = b[3:0]; end
  endtask

  // Random in_valid/operands; only driven while the DUT is not ready.
  task automatic junk(input int sel);
    drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), 16'($urandom));
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic send(input int sel, input bit sub, input logic [15:0] a,
                      input logic [15:0] b, output int acc);
    int    n;
    exp_t  e;
    string p;
    p = (sel == 0) ? "dut4" : "dut1";
    n = 0; acc = -1;
    while (!((sel == 0) ? rdy4 : rdy1)) begin
      n = n + 1;
      if (n > 300) begin chk({p, "_ready_timeout"}, 0, 1); return; end
      junk(sel);
      @(negedge clk);
    end
    drive(sel, 1, sub, a, b);
    @(posedge clk); #1;
    acc = cyc;
    e = model((sel == 0) ? 16 : 4, sub, a, b);
    e.due = cyc + ((sel == 0) ? 4 : 1);
    if (sel == 0) q4.push_back(e); else q1.push_back(e);
    n = 0;
    @(negedge clk);
    while (!((sel == 0) ? rdy4 : rdy1)) begin
      n = n + 1;
      if (n > 300) begin chk({p, "_done_timeout"}, 0, 1); break; end
      junk(sel);
      @(negedge clk);
    end
    drive(sel, 0, 0, 0, 0);
  endtask

  // Monitors: compare head of queue every cycle out_valid is high (so held
  // outputs are re-checked), pop on the handshake.
  initial begin
    bit pv = 0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && ov4) begin
        if (q4.size() == 0) chk("dut4_unexpected_valid", 1, 0);
        else begin
          e = q4[0];
          if (!pv) chk("dut4_latency", cyc, e.due);
          chk("dut4_result", r4, e.res);
          chk("dut4_carry", c4, e.carry);
          chk("dut4_overflow", o4, e.ovf);
          chk("dut4_zero", z4, e.zero);
          chk("dut4_in_ready_done", rdy4, 0);
          if (ordy4) void'(q4.pop_front());
        end
      end
      pv = ov4 && !rst;
    end
  end

  initial begin
    bit pv = 0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && ov1) begin
        if (q1.size() == 0) chk("dut1_unexpected_valid", 1, 0);
        else begin
          e = q1[0];
          if (!pv) chk("dut1_latency", cyc, e.due);
          chk("dut1_result", r1, e.res);
          chk("dut1_carry", c1, e.carry);
          chk("dut1_overflow", o1, e.ovf);
          chk("dut1_zero", z1, e.zero);
          if (ordy1) void'(q1.pop_front());
        end
      end
      pv = ov1 && !rst;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rnd_bp) ordy4 = 1'($urandom_range(0, 1));
  end

  initial begin
    int acc, prev, t;
    logic [15:0] va [5] = '{16'h1234, 16'h0005, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] vb [5] = '{16'h0FFF, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
    bit          vs [5] = '{0, 1, 0, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", ov4, 0);
    chk("rst_in_ready", rdy4, 0);
    chk("rst_result", r4, 0);
    chk("rst_flags", {c4, o4, z4, bz4}, 0);
    rst = 0;
    #1 chk("post_rst_in_ready", rdy4, 1);

    // Abort mid-CALC: nothing may come out for this request
    @(negedge clk);
    drive(0, 1, 0, 16'h1234, 16'h0FFF);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    chk("abort_busy_calc", bz4, 1);
    chk("abort_in_ready_calc", rdy4, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    #1;
    chk("abort_out_valid", ov4, 0);
    chk("abort_result", r4, 0);
    chk("abort_flags", {c4, o4, z4, bz4}, 0);
    chk("abort_in_ready_rst", rdy4, 0);
    @(negedge clk); rst = 0;
    #1 chk("abort_in_ready_release", rdy4, 1);
    @(posedge clk); #1;
    chk("abort_idle_after_edge", {rdy4, bz4, ov4}, 3'b100);
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 5; i++) send(0, vs[i], va[i], vb[i], acc);

    // Backpressure: SUB 0-1 held 5 cycles, junk in_valid meanwhile
    ordy4 = 0;
    fork
      send(0, 1, 16'h0000, 16'h0001, acc);
      begin
        t = 0;
        while (!ov4 && t < 100) begin @(negedge clk); t = t + 1; end
        repeat (5) @(negedge clk);
        ordy4 = 1;
      end
    join

    // Random with random backpressure
    rnd_bp = 1;
    repeat (30) send(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), acc);
    rnd_bp = 0;
    @(negedge clk); ordy4 = 1;

    // Back-to-back spacing, NIBBLES=4
    prev = -1;
    repeat (4) begin
      send(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), acc);
      if (prev >= 0) chk("dut4_spacing", acc - prev, 6);
      prev = acc;
    end

    // NIBBLES=1: 9+8 then back-to-back random
    send(1, 0, 16'h9, 16'h8, acc);
    prev = acc;
    repeat (12) begin
      send(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), acc);
      chk("dut1_spacing", acc - prev, 3);
      prev = acc;
    end

    t = 0;
    while ((q4.size() != 0 || q1.size() != 0) && t < 200) begin @(negedge clk); t = t + 1; end
    repeat (3) @(negedge clk);
    chk("dut4_queue_drained", q4.size(), 0);
    chk("dut1_queue_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addsub_nibble_seq.md
Name: addsub_nibble_seq

Overview:
- Sequential operand engine for the 4-bit add/subtract stage.
- Accepts wide operands over a valid/ready handshake and processes them one nibble per cycle through a 4-bit add/subtract slice.
- Chains carry between nibbles and presents a registered result with flags on a valid/ready output.
- Sits directly upstream of the result consumers and wraps the team's 4-bit add/sub datapath into a multi-cycle wide operation.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with operands.
- a  input  W  operand A.
- b  input  W  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  A+B or A-B, modulo 2^W.
- carry  output  1  final carry-out; for subtract, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, nibble counter=0, internal carry=0, operand/result registers=0. Outputs: out_valid=0, result=0, carry=0, overflow=0, zero=0, busy=0, in_ready=0 while rst high.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, op_sub; set chain carry = op_sub; counter=0; go to CALC.
  - CALC: in_ready=0. Each edge processes nibble k = counter:
    - {c,s} = A[k] + (B[k] XOR {4{op_sub}}) + c_prev
    - s is written to result nibble k; c becomes c_prev.
    - Counter increments. On the edge processing k = NIBBLES-1, register final carry and flags, then go to DONE.
  - DONE: out_valid=1; result and flags held stable. On out_valid&&out_ready, go to IDLE (out_valid=0 next cycle). in_ready=0 in DONE; there is no same-cycle bypass into a new request.
- Latency:
  - out_valid rises NIBBLES edges after the accepting edge.
  - Minimum request spacing is NIBBLES+2 cycles when out_ready is held high.
- Flags, from captured operands and final result. MSB is bit W-1. B' = B XOR {W{op_sub}}.
  - overflow = (A_msb == B'_msb) && (result_msb != A_msb).
  - zero = (result == 0).
  - carry = carry out of nibble NIBBLES-1.
- In-flight inputs: in_valid is ignored in CALC and DONE. Operand inputs may change freely after acceptance without affecting the computation.
- Backpressure: out_ready low in DONE holds every output indefinitely. out_ready high in any state other than DONE has no effect.
- Reset mid-operation (CALC or DONE): the operation is aborted immediately. No out_valid pulse follows; the block is in IDLE on the first edge after rst deasserts.
- NIBBLES=1: CALC lasts exactly one cycle.

Test Plan:
- Reset mid-CALC: accept ADD 0x1234+0x0FFF, assert rst after 2 edges, release. Required: out_valid never rises for that request; outputs=0; in_ready=1 on the first cycle after release.
- ADD 0x1234+0x0FFF (NIBBLES=4). Required: result=0x2233, carry=0, overflow=0, zero=0; out_valid rises exactly 4 edges after the accepting edge; in_ready=0 through CALC/DONE.
- SUB 0x0005-0x0005. Required: result=0x0000, carry=1, zero=1, overflow=0. SUB 0x0000-0x0001 with out_ready held low 5 cycles. Required: result=0xFFFF, carry=0, overflow=0, all outputs stable while held, in_valid pulses ignored.
- ADD 0x7FFF+0x0001. Required: result=0x8000, overflow=1, carry=0. SUB 0x8000-0x0001. Required: result=0x7FFF, overflow=1, carry=1.
- ADD 0xFFFF+0x0001. Required: result=0x0000, carry=1, zero=1, overflow=0 (carry propagates across all four nibbles).
- NIBBLES=1: ADD 0x9+0x8. Required: result=0x1, carry=1, overflow=1, out_valid 1 edge after accept. Back-to-back requests with out_ready=1. Required: accepts spaced exactly 3 cycles.
